// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core -- multi-cycle 8-bit ALU: add, subtract, signed multiply (radix-2
// Booth) and unsigned divide (non-restoring), sharing one A/Q/M datapath.
//
// Ports
//   clk      in   1   rising-edge clock for all state
//   rst      in   1   asynchronous active-low reset
//   start    in   1   begins an operation when sampled high in IDLE
//   sel      in   2   00 add, 01 sub, 10 signed mul, 11 unsigned div
//   inbus    in  16   operands (first word at start edge, M two edges later)
//   outbus   out 16   registered result, held until the next OUT state
//   finish   out  1   one-cycle completion pulse (high while in DONE)
//   of_flag  out  1   signed overflow of add/sub (or divide overflow)
//
// Build option
//   ALU_DIV_OVF_CHECK_EN  when defined, a divide whose quotient cannot fit in
//                         8 bits (dividend high byte >= M, incl. M = 0) skips
//                         the iterations and returns 16'hFFFF with of_flag=1.
// ---------------------------------------------------------------------------
module alu_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  sel,
    input  logic [15:0] inbus,
    output logic [15:0] outbus,
    output logic        finish,
    output logic        of_flag
);

    typedef enum logic [2:0] {
        IDLE, GAP, LOADM, EXEC, CORR, OUT, DONE
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    state_t      state, state_next;
    logic [8:0]  a;
    logic [7:0]  q;
    logic [7:0]  m;
    logic        q_m1;
    logic [2:0]  count;
    logic [1:0]  op;
`ifdef ALU_DIV_OVF_CHECK_EN
    logic        div_ovf;
`endif

    logic        sub_op;
    logic [7:0]  addsub_b;
    logic [7:0]  addsub_res;
    logic        addsub_ovf;
    logic [8:0]  m_sext;
    logic [8:0]  m_zext;
    logic [8:0]  booth_acc;
    logic [8:0]  div_shift;
    logic [8:0]  div_acc;

    // Arithmetic for one EXEC step. The Booth accumulator runs on all 9 bits
    // of A with a sign-extended M so that M = -128 cannot overflow the
    // partial sum; the product still ends up in {A[7:0], Q}.
    always_comb begin
        sub_op     = (op == OP_SUB);
        addsub_b   = sub_op ? ~m : m;
        addsub_res = a[7:0] + addsub_b + {7'd0, sub_op};
        addsub_ovf = (a[7] == addsub_b[7]) && (addsub_res[7] != a[7]);

        m_sext = {m[7], m};
        m_zext = {1'b0, m};

        booth_acc = a;
        case ({q[0], q_m1})
            2'b10:   booth_acc = a - m_sext;
            2'b01:   booth_acc = a + m_sext;
            default: booth_acc = a;
        endcase

        div_shift = {a[7:0], q[7]};
        div_acc   = a[8] ? (div_shift + m_zext) : (div_shift - m_zext);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sequencing. Add/sub leave EXEC after one cycle; multiply and divide
    // iterate until the counter reaches 7, and only divide needs CORR.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = GAP;
            GAP:   state_next = LOADM;
            LOADM: begin
                state_next = EXEC;
`ifdef ALU_DIV_OVF_CHECK_EN
                if ((op == OP_DIV) && (a[7:0] >= inbus[7:0])) state_next = OUT;
`endif
            end
            EXEC: begin
                if ((op == OP_ADD) || (op == OP_SUB)) begin
                    state_next = OUT;
                end else if (count == 3'd7) begin
                    state_next = (op == OP_DIV) ? CORR : OUT;
                end
            end
            CORR:    state_next = OUT;
            OUT:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers and the registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a       <= '0;
            q       <= '0;
            m       <= '0;
            q_m1    <= 1'b0;
            count   <= '0;
            op      <= OP_ADD;
            outbus  <= '0;
            of_flag <= 1'b0;
`ifdef ALU_DIV_OVF_CHECK_EN
            div_ovf <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op      <= sel;
                        count   <= '0;
                        of_flag <= 1'b0;
`ifdef ALU_DIV_OVF_CHECK_EN
                        div_ovf <= 1'b0;
`endif
                        case (sel)
                            OP_MUL: begin
                                q    <= inbus[7:0];
                                a    <= '0;
                                q_m1 <= 1'b0;
                            end
                            OP_DIV: begin
                                a <= {1'b0, inbus[15:8]};
                                q <= inbus[7:0];
                            end
                            default: a <= {1'b0, inbus[7:0]};
                        endcase
                    end
                end
                LOADM: begin
                    m <= inbus[7:0];
`ifdef ALU_DIV_OVF_CHECK_EN
                    // The dividend high byte already sits in A; the quotient
                    // only fits in 8 bits when that byte is below M.
                    div_ovf <= (op == OP_DIV) && (a[7:0] >= inbus[7:0]);
`endif
                end
                EXEC: begin
                    count <= count + 3'd1;
                    case (op)
                        OP_MUL: begin
                            a    <= {booth_acc[8], booth_acc[8:1]};
                            q    <= {booth_acc[0], q[7:1]};
                            q_m1 <= q[0];
                        end
                        OP_DIV: begin
                            a <= div_acc;
                            q <= {q[6:0], ~div_acc[8]};
                        end
                        default: begin
                            a       <= {1'b0, addsub_res};
                            of_flag <= addsub_ovf;
                        end
                    endcase
                end
                CORR: begin
                    if (a[8]) a <= a + m_zext;
                end
                OUT: begin
                    if ((op == OP_ADD) || (op == OP_SUB)) begin
                        outbus <= {8'h00, a[7:0]};
                    end else begin
                        outbus <= {a[7:0], q};
                    end
`ifdef ALU_DIV_OVF_CHECK_EN
                    if (div_ovf) begin
                        outbus  <= 16'hFFFF;
                        of_flag <= 1'b1;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign finish = (state == DONE);

endmodule

// File: tb/tb_alu_core.sv
// ---------------------------------------------------------------------------
// tb_alu_core -- self-checking bench for alu_core. Directed examples followed
// by random operations; expected results come from plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_alu_core;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  sel;
    logic [15:0] inbus;
    logic [15:0] outbus;
    logic        finish;
    logic        of_flag;

    int          tests_run;
    int          tests_failed;
    logic [15:0] last_out;
    bit          hold_known;

    alu_core dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .sel     (sel),
        .inbus   (inbus),
        .outbus  (outbus),
        .finish  (finish),
        .of_flag (of_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Runs one operation from IDLE, keeping start/sel noisy while busy, and
    // checks latency, result, overflow, flag clearing and output hold.
    task automatic applyStimulus(input logic [1:0] op, input logic [15:0] opa,
                                 input logic [7:0] opm);
        logic [15:0] exp_out;
        logic        exp_of;
        int          exp_lat;
        bit          check_out;
        int          sa, sm, r, qq, rr, lat_obs;

        sa        = int'($signed(opa[7:0]));
        sm        = int'($signed(opm));
        check_out = 1'b1;
        exp_of    = 1'b0;
        exp_out   = 16'h0000;
        exp_lat   = 4;
        case (op)
            2'b00: begin
                r = sa + sm;
                exp_out = {8'h00, r[7:0]};
                exp_of  = (r > 127) || (r < -128);
            end
            2'b01: begin
                r = sa - sm;
                exp_out = {8'h00, r[7:0]};
                exp_of  = (r > 127) || (r < -128);
            end
            2'b10: begin
                r = sa * sm;
                exp_out = r[15:0];
                exp_lat = 11;
            end
            default: begin
                if (opa[15:8] >= opm) begin
`ifdef ALU_DIV_OVF_CHECK_EN
                    exp_out = 16'hFFFF;
                    exp_of  = 1'b1;
                    exp_lat = 3;
`else
                    check_out = 1'b0;
                    exp_lat   = 12;
`endif
                end else begin
                    qq = int'(opa) / int'(opm);
                    rr = int'(opa) % int'(opm);
                    exp_out = {rr[7:0], qq[7:0]};
                    exp_lat = 12;
                end
            end
        endcase

        start = 1'b1;
        sel   = op;
        inbus = opa;
        @(posedge clk); #1;
        start = 1'($urandom_range(0, 1));
        sel   = 2'($urandom_range(0, 3));
        inbus = 16'($urandom);
        checkOutput("of_flag_cleared", 32'(of_flag), 32'd0);
        @(posedge clk); #1;
        if (hold_known) checkOutput("outbus_hold", 32'(outbus), 32'(last_out));
        start = 1'($urandom_range(0, 1));
        inbus = {opa[15:8], opm};
        @(posedge clk); #1;
        inbus   = 16'($urandom);
        lat_obs = 0;
        for (int k = 3; k <= 25; k++) begin
            start = 1'($urandom_range(0, 1));
            sel   = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
            if (finish) begin
                lat_obs = k;
                start   = 1'b0;
                break;
            end
        end
        start = 1'b0;
        checkOutput("latency", 32'(lat_obs), 32'(exp_lat));
        if (check_out) checkOutput("outbus", 32'(outbus), 32'(exp_out));
        checkOutput("of_flag", 32'(of_flag), 32'(exp_of));
        hold_known = check_out;
        last_out   = exp_out;
        @(posedge clk); #1;
        checkOutput("finish_pulse", 32'(finish), 32'd0);
    endtask

    initial begin
        logic [7:0] rm;
        logic [7:0] rh;
        logic [1:0] rop;

        tests_run    = 0;
        tests_failed = 0;
        last_out     = 16'h0000;
        hold_known   = 1'b1;
        rst   = 1'b0;
        start = 1'b0;
        sel   = 2'b00;
        inbus = 16'h0000;

        #12;
        checkOutput("reset_outbus", 32'(outbus), 32'd0);
        checkOutput("reset_finish", 32'(finish), 32'd0);
        checkOutput("reset_of_flag", 32'(of_flag), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        applyStimulus(2'b00, 16'd20, 8'd75);
        applyStimulus(2'b00, 16'd127, 8'd126);
        applyStimulus(2'b01, 16'd178, 8'd34);
        applyStimulus(2'b01, 16'h0080, 8'h01);
        applyStimulus(2'b10, 16'd40, 8'd12);
        applyStimulus(2'b10, 16'h00E7, 8'hD6);
        applyStimulus(2'b11, 16'd5771, 8'd135);
        applyStimulus(2'b11, 16'h1000, 8'h10);
        applyStimulus(2'b10, 16'h00E9, 8'h4B);
        applyStimulus(2'b10, 16'h0080, 8'h80);

        // Abort a multiply part-way through with reset.
        start = 1'b1;
        sel   = 2'b10;
        inbus = 16'h0077;
        @(posedge clk); #1;
        start = 1'b0;
        inbus = 16'h0033;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midreset_outbus", 32'(outbus), 32'd0);
        checkOutput("midreset_finish", 32'(finish), 32'd0);
        checkOutput("midreset_of_flag", 32'(of_flag), 32'd0);
        @(posedge clk); #1;
        rst        = 1'b1;
        last_out   = 16'h0000;
        hold_known = 1'b1;
        @(posedge clk); #1;
        applyStimulus(2'b00, 16'd1, 8'd1);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            if (rop == 2'b11) begin
                rm = 8'($urandom_range(1, 255));
                rh = 8'($urandom_range(0, int'(rm) - 1));
                applyStimulus(rop, {rh, 8'($urandom)}, rm);
            end else begin
                applyStimulus(rop, 16'($urandom), 8'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
